// File: rtl/receiver.sv
// UART receive stage: 2-flop synchronised RX, 16x-oversampled mid-bit sampling,
// 5..9 data bits LSB first, optional even parity, 1 or 2 stop bits, sticky status.
module receiver #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic        the_new_generated_clock,
   input  logic        reset_n,
   input  logic        sample_tick,
   input  logic        RX,
   input  logic [31:0] Receiver_Control,
   input  logic        rx_read,
   output logic [31:0] Receiver_Buffer_Register,
   output logic [31:0] Receiver_Status
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

   typedef enum logic [5:0] {
      IDLE   = 6'b000001,
      START  = 6'b000010,
      DATA   = 6'b000100,
      PARITY = 6'b001000,
      STOP   = 6'b010000,
      DONE   = 6'b100000
   } state_t;

   state_t           state;
   logic             rx_m;
   logic             rx_s;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       idx;
   logic [3:0]       nbits;
   logic             par_en;
   logic             two_stop;
   logic             stop_idx;
   logic [8:0]       shreg;
   logic             perr;
   logic             ferr;
   logic [8:0]       rbuf;
   logic             dr;
   logic             pe;
   logic             fe;
   logic             ovr;

   logic             cfg_en;
   logic [3:0]       cfg_bits;
   logic             cfg_ok;
   logic             unused_ctrl;

   assign cfg_en      = Receiver_Control[0];
   assign cfg_bits    = Receiver_Control[4:1];
   assign cfg_ok      = cfg_en && (cfg_bits >= 4'd5) && (cfg_bits <= 4'd9);
   assign unused_ctrl = ^Receiver_Control[31:8];

   assign Receiver_Buffer_Register = {23'd0, rbuf};
   assign Receiver_Status          = {27'd0, (state != IDLE), ovr, fe, pe, dr};

   // Synchroniser, frame FSM and sticky status; a DONE in the same cycle as rx_read wins.
   always_ff @(posedge the_new_generated_clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         rx_m     <= 1'b1;
         rx_s     <= 1'b1;
         cnt      <= '0;
         idx      <= '0;
         nbits    <= '0;
         par_en   <= 1'b0;
         two_stop <= 1'b0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
         rbuf     <= '0;
         dr       <= 1'b0;
         pe       <= 1'b0;
         fe       <= 1'b0;
         ovr      <= 1'b0;
      end else begin
         rx_m <= RX;
         rx_s <= rx_m;

         if (rx_read) begin
            dr  <= 1'b0;
            pe  <= 1'b0;
            fe  <= 1'b0;
            ovr <= 1'b0;
         end

         if (!cfg_ok && (state != IDLE)) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (cfg_ok && !rx_s) begin
                     state    <= START;
                     cnt      <= '0;
                     nbits    <= cfg_bits;
                     par_en   <= Receiver_Control[5];
                     two_stop <= (Receiver_Control[7:6] == 2'd2);
                     shreg    <= '0;
                     perr     <= 1'b0;
                     ferr     <= 1'b0;
                  end
               end
               START: begin
                  if (sample_tick) begin
                     cnt <= cnt + 1'b1;
                     if (cnt == CNT_HALF) begin
                        if (!rx_s) begin
                           state <= DATA;
                           cnt   <= '0;
                           idx   <= '0;
                        end else begin
                           state <= IDLE;
                        end
                     end
                  end
               end
               DATA: begin
                  if (sample_tick) begin
                     cnt <= cnt + 1'b1;
                     if (cnt == CNT_LAST) begin
                        shreg[idx] <= rx_s;
                        idx        <= idx + 4'd1;
                        stop_idx   <= 1'b0;
                        if (idx == nbits - 4'd1) begin
                           state <= par_en ? PARITY : STOP;
                        end
                     end
                  end
               end
               PARITY: begin
                  if (sample_tick) begin
                     cnt <= cnt + 1'b1;
                     if (cnt == CNT_LAST) begin
                        perr  <= (rx_s != ^shreg);
                        state <= STOP;
                     end
                  end
               end
               STOP: begin
                  if (sample_tick) begin
                     cnt <= cnt + 1'b1;
                     if (cnt == CNT_LAST) begin
                        if (!rx_s) begin
                           ferr <= 1'b1;
                        end
                        if (two_stop && !stop_idx) begin
                           stop_idx <= 1'b1;
                        end else begin
                           state <= DONE;
                        end
                     end
                  end
               end
               DONE: begin
                  rbuf  <= shreg;
                  dr    <= 1'b1;
                  pe    <= perr;
                  fe    <= ferr;
                  ovr   <= !rx_read && (ovr || dr);
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
